data_rate_meter: RTL and testbench
==================================

// Module: data_rate_meter
// PURPOSE
//   Multi-channel successor to the single-channel sample-rate counter.
//   Counts rising edges of each channel's data-valid strobe over a fixed, parametrised window.
//   Publishes per-channel rate, min/max statistics, stall and saturation flags.
//   Sits beside the G-sensor SPI reader and the display/UART path; one channel per axis by default.
// PARAMETERS
//   NCH        3           number of independent valid-strobe channels (>=1)
//   CNT_W      16          width of each per-channel count / rate field
//   WINDOW_CYC 50000000    clock cycles per measurement window (>=2; 1 s at 50 MHz)
// PORTS
//   iClk        in   1          system clock (single clock domain)
//   iRst        in   1          synchronous, active-high reset
//   iDataValid  in   NCH        per-channel valid strobe; bit c = channel c (level, any width)
//   iClrStats   in   1          1-cycle pulse: clear min/max statistics of all channels
//   oRate       out  NCH*CNT_W  last completed-window edge count; channel c at [c*CNT_W +: CNT_W]
//   oRateMin    out  NCH*CNT_W  minimum oRate since reset/clear, same packing
//   oRateMax    out  NCH*CNT_W  maximum oRate since reset/clear, same packing
//   oSat        out  NCH        last completed window saturated its counter
//   oStall      out  NCH        last completed window counted zero edges
//   oUpdate     out  1          1-cycle pulse: oRate/min/max/flags just updated
//   oRateValid  out  1          high once at least one window has completed since reset
// BEHAVIOUR
// - Reset (iRst high at a clock edge):
//   - Window counter, per-channel counters, oRate, oRateMax, oSat, oStall, oUpdate, oRateValid -> 0.
//   - oRateMin -> all-ones.
//   - Edge-detect history register -> all-ones, so a strobe already high at reset release is not counted.
//   - Reset asserted mid-window discards the partial window; no oUpdate is produced.
// - Window timer: counts 0..WINDOW_CYC-1 then wraps.
//   - tick = (timer == WINDOW_CYC-1), high for exactly 1 cycle per window.
//   - First tick occurs WINDOW_CYC cycles after reset release.
// - Edge detect per channel: edge[c] = iDataValid[c] & ~prev[c]; prev is registered every cycle.
//   - At most 1 count per channel per cycle.
// - Per-channel counter, non-tick cycle:
//   - edge -> cnt+1, saturating at 2^CNT_W-1 (holds, never wraps).
//   - Sticky sat bit sets when an edge arrives while cnt is already all-ones.
// - Tick cycle T; all results visible at T+1:
//   - closing = sat_add(cnt, edge). An edge in cycle T belongs to the closing window, never lost.
//   - oRate[c] <= closing.
//   - oSat[c] <= sat bit (including overflow in T).
//   - oStall[c] <= (closing == 0).
//   - oRateMin[c] <= min(oRateMin[c], closing); oRateMax[c] <= max(oRateMax[c], closing).
//   - cnt and sat bit -> 0.
//   - oUpdate = 1 for cycle T+1 only; oRateValid <= 1 and stays 1 until reset.
// - iClrStats, no coincident tick: oRateMin -> all-ones, oRateMax -> 0 next cycle. oRate and flags untouched.
// - iClrStats coincident with tick: the clear wins for statistics.
//   - min -> all-ones, max -> 0.
//   - oRate, oSat, oStall, oUpdate still update normally.
// - Channels are fully independent; simultaneous edges on all channels each count.
// - Outputs are registered only; no combinational path from inputs to outputs.
// TESTING (bench uses WINDOW_CYC=100, CNT_W=4, NCH=3)
// - Reset with iDataValid=3'b111 held high, release, pulse nothing for 100 cycles
//   -> oUpdate at cycle 100, oRate=0 all channels, oStall=3'b111, oRateValid=1.
// - Ch0 5 pulses, ch1 2 pulses, ch2 a single level held high for the whole window
//   -> oRate = {1,2,5} (ch2,ch1,ch0), oStall=0.
// - Ch0 edge exactly on the tick cycle -> counted in the closing window (oRate ch0 = prior+1);
//   next window starts from 0.
// - Ch1 20 pulses in one window -> oRate ch1 = 15, oSat[1]=1; next window with 3 pulses -> 3, oSat[1]=0.
// - Windows with ch0 rates 7,3,9 -> oRateMin=3, oRateMax=9.
//   - iClrStats in a non-tick cycle -> min=15, max=0.
//   - iClrStats coincident with a tick -> min=15, max=0, oRate still updated.
// - iRst pulsed at cycle 60 of a window with pulses pending -> all outputs at reset values,
//   no oUpdate until 100 cycles after release.

Source files
------------

// File: rtl/data_rate_meter.sv
// rtl/data_rate_meter.sv - per-channel valid-strobe edge counter over a fixed window
// Publishes rate, min/max statistics, stall and saturation flags once per window.
module data_rate_meter #(
  parameter int NCH        = 3,
  parameter int CNT_W      = 16,
  parameter int WINDOW_CYC = 50000000
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NCH-1:0]       iDataValid,
  input  logic                 iClrStats,
  output logic [NCH*CNT_W-1:0] oRate,
  output logic [NCH*CNT_W-1:0] oRateMin,
  output logic [NCH*CNT_W-1:0] oRateMax,
  output logic [NCH-1:0]       oSat,
  output logic [NCH-1:0]       oStall,
  output logic                 oUpdate,
  output logic                 oRateValid
);

  localparam int TW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [TW-1:0]    TMAX    = TW'(WINDOW_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TW-1:0]                 timer_q, timer_d;
  logic [NCH-1:0]                prev_q;
  logic [NCH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NCH-1:0]                sat_q, sat_d;
  logic [NCH-1:0][CNT_W-1:0]     rate_q, rate_d;
  logic [NCH-1:0][CNT_W-1:0]     min_q, min_d;
  logic [NCH-1:0][CNT_W-1:0]     max_q, max_d;
  logic [NCH-1:0]                osat_q, osat_d;
  logic [NCH-1:0]                stall_q, stall_d;
  logic                          upd_q, upd_d;
  logic                          valid_q, valid_d;

  logic                          tick;
  logic [NCH-1:0]                edge_det;
  logic [NCH-1:0]                ovf;
  logic [NCH-1:0][CNT_W-1:0]     closing;

  always_comb begin
    tick     = (timer_q == TMAX);
    edge_det = iDataValid & ~prev_q;
    timer_d  = tick ? '0 : timer_q + TW'(1);
    upd_d    = tick;
    valid_d  = valid_q | tick;
    ovf      = '0;
    closing  = cnt_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    rate_d   = rate_q;
    min_d    = min_q;
    max_d    = max_q;
    osat_d   = osat_q;
    stall_d  = stall_q;
    for (int c = 0; c < NCH; c++) begin
      // Saturating add: an edge on an already full counter only flags overflow.
      ovf[c]     = edge_det[c] & (cnt_q[c] == CNT_MAX);
      closing[c] = (cnt_q[c] == CNT_MAX) ? CNT_MAX : cnt_q[c] + CNT_W'(edge_det[c]);
      if (tick) begin
        cnt_d[c]   = '0;
        sat_d[c]   = 1'b0;
        rate_d[c]  = closing[c];
        osat_d[c]  = sat_q[c] | ovf[c];
        stall_d[c] = (closing[c] == '0);
        min_d[c]   = (closing[c] < min_q[c]) ? closing[c] : min_q[c];
        max_d[c]   = (closing[c] > max_q[c]) ? closing[c] : max_q[c];
      end else begin
        cnt_d[c] = closing[c];
        sat_d[c] = sat_q[c] | ovf[c];
      end
      // Clear takes priority over a coincident window update of the statistics.
      if (iClrStats) begin
        min_d[c] = CNT_MAX;
        max_d[c] = '0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      timer_q <= '0;
      prev_q  <= '1;
      cnt_q   <= '0;
      sat_q   <= '0;
      rate_q  <= '0;
      min_q   <= {NCH{CNT_MAX}};
      max_q   <= '0;
      osat_q  <= '0;
      stall_q <= '0;
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      prev_q  <= iDataValid;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      rate_q  <= rate_d;
      min_q   <= min_d;
      max_q   <= max_d;
      osat_q  <= osat_d;
      stall_q <= stall_d;
      upd_q   <= upd_d;
      valid_q <= valid_d;
    end
  end

  assign oRate      = rate_q;
  assign oRateMin   = min_q;
  assign oRateMax   = max_q;
  assign oSat       = osat_q;
  assign oStall     = stall_q;
  assign oUpdate    = upd_q;
  assign oRateValid = valid_q;

endmodule

// File: tb/tb_data_rate_meter.sv
// tb/tb_data_rate_meter.sv - directed-vector bench for data_rate_meter
// Small window (100 cycles), 4-bit counters, 3 channels.
module tb_data_rate_meter;

  localparam int NCH   = 3;
  localparam int CNT_W = 4;
  localparam int WIN   = 100;

  logic                 clk;
  logic                 rst;
  logic [NCH-1:0]       dv;
  logic                 clr;
  logic [NCH*CNT_W-1:0] rate, rmin, rmax;
  logic [NCH-1:0]       sat, stall;
  logic                 upd, rvalid;

  int nvec = 0;
  int nmis = 0;

  data_rate_meter #(.NCH(NCH), .CNT_W(CNT_W), .WINDOW_CYC(WIN)) dut (
    .iClk(clk), .iRst(rst), .iDataValid(dv), .iClrStats(clr),
    .oRate(rate), .oRateMin(rmin), .oRateMax(rmax),
    .oSat(sat), .oStall(stall), .oUpdate(upd), .oRateValid(rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full window; channel c pulses on odd cycles 1,3,..,2n-1 (n rising edges).
  task automatic run_window(input int n0, input int n1, input int n2, input bit hold2,
                            input bit tick0, input int clr_at);
    int spur;
    spur = 0;
    for (int i = 0; i < WIN; i++) begin
      dv[0] = ((i % 2 == 1) && (i < 2 * n0)) || (tick0 && i == WIN - 1);
      dv[1] = (i % 2 == 1) && (i < 2 * n1);
      dv[2] = hold2 ? 1'b1 : ((i % 2 == 1) && (i < 2 * n2));
      clr   = (i == clr_at);
      cyc();
      if (i < WIN - 1 && upd) spur++;
      if (i == clr_at && i < WIN - 1) begin
        check("clr_min", 32'(rmin), 32'hFFF);
        check("clr_max", 32'(rmax), 32'h000);
      end
    end
    clr = 1'b0;
    check("upd_spurious", spur, 0);
    check("update", 32'(upd), 1);
  endtask

  initial begin
    int spur;
    rst = 1'b1;
    dv  = 3'b111;
    clr = 1'b0;
    cyc();
    cyc();
    check("rst_rate", 32'(rate), 32'h000);
    check("rst_min", 32'(rmin), 32'hFFF);
    check("rst_max", 32'(rmax), 32'h000);
    check("rst_upd", 32'(upd), 0);
    check("rst_valid", 32'(rvalid), 0);
    rst = 1'b0;

    // W1: strobes held high since reset, no rising edges.
    spur = 0;
    for (int i = 0; i < WIN; i++) begin
      dv = (i < WIN - 1) ? 3'b111 : 3'b000;
      cyc();
      if (i < WIN - 1 && upd) spur++;
    end
    check("w1_spurious", spur, 0);
    check("w1_upd", 32'(upd), 1);
    check("w1_rate", 32'(rate), 32'h000);
    check("w1_stall", 32'(stall), 32'h7);
    check("w1_valid", 32'(rvalid), 1);

    // W2: 5 / 2 pulses, ch2 a single level across the window.
    run_window(5, 2, 0, 1'b1, 1'b0, -1);
    check("w2_rate", 32'(rate), 32'h125);
    check("w2_stall", 32'(stall), 32'h0);

    // W3: ch0 edge on the tick cycle belongs to the closing window.
    run_window(4, 0, 0, 1'b0, 1'b1, -1);
    check("w3_rate", 32'(rate), 32'h005);
    check("w3_stall", 32'(stall), 32'h6);

    // W4: ch0 restarts from zero; ch1 saturates.
    run_window(3, 20, 0, 1'b0, 1'b0, -1);
    check("w4_rate", 32'(rate), 32'h0F3);
    check("w4_sat", 32'(sat), 32'h2);
    check("w4_stall", 32'(stall), 32'h4);

    run_window(0, 3, 0, 1'b0, 1'b0, -1);
    check("w5_rate", 32'(rate), 32'h030);
    check("w5_sat", 32'(sat), 32'h0);
    check("w5_stall", 32'(stall), 32'h5);

    // W6..W8: clear mid-window, then ch0 rates 7,3,9.
    run_window(7, 0, 0, 1'b0, 1'b0, 50);
    check("w6_rate", 32'(rate), 32'h007);
    check("w6_min", 32'(rmin), 32'h007);
    check("w6_max", 32'(rmax), 32'h007);
    run_window(3, 0, 0, 1'b0, 1'b0, -1);
    check("w7_min", 32'(rmin), 32'h003);
    check("w7_max", 32'(rmax), 32'h007);
    run_window(9, 0, 0, 1'b0, 1'b0, -1);
    check("w8_rate", 32'(rate), 32'h009);
    check("w8_min", 32'(rmin), 32'h003);
    check("w8_max", 32'(rmax), 32'h009);

    // W9: clear coincident with the tick.
    run_window(4, 0, 0, 1'b0, 1'b0, WIN - 1);
    check("w9_rate", 32'(rate), 32'h004);
    check("w9_min", 32'(rmin), 32'hFFF);
    check("w9_max", 32'(rmax), 32'h000);
    check("w9_stall", 32'(stall), 32'h6);

    // W10: reset at cycle 60 with pulses counted.
    for (int i = 0; i < 60; i++) begin
      dv = ((i % 2 == 1) && (i < 10)) ? 3'b111 : 3'b000;
      cyc();
    end
    dv  = 3'b000;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_rate", 32'(rate), 32'h000);
    check("mrst_min", 32'(rmin), 32'hFFF);
    check("mrst_max", 32'(rmax), 32'h000);
    check("mrst_flags", 32'({sat, stall}), 32'h00);
    check("mrst_upd", 32'(upd), 0);
    check("mrst_valid", 32'(rvalid), 0);
    spur = 0;
    for (int i = 0; i < WIN; i++) begin
      cyc();
      if (i < WIN - 1 && upd) spur++;
    end
    check("mrst_spurious", spur, 0);
    check("mrst_upd_after", 32'(upd), 1);
    check("mrst_rate_after", 32'(rate), 32'h000);
    check("mrst_stall_after", 32'(stall), 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
